// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one signed multiplier between two requesters.
// Each product is returned through a per-requester result register with ack.
module mul_share_arbiter #(
  parameter int N       = 8,
  parameter int M       = 8,
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [N-1:0]   req0_a,
  input  logic [M-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [N-1:0]   req1_a,
  input  logic [M-1:0]   req1_b,
  output logic           req1_ready,
  output logic           res0_valid,
  output logic [N+M-1:0] res0_y,
  input  logic           res0_ack,
  output logic           res1_valid,
  output logic [N+M-1:0] res1_y,
  input  logic           res1_ack,
  output logic           mul_start,
  output logic [N-1:0]   mul_a,
  output logic [M-1:0]   mul_b,
  input  logic [N+M-1:0] mul_y,
  input  logic           mul_done,
  input  logic           mul_aval,
  output logic           busy,
  output logic           err_to,
  output logic           err_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

  state_t        state;
  logic          rr;
  logic          owner;
  logic [TW-1:0] timer;
  logic          elig0, elig1, grant1;

  assign elig0  = req0_valid & ~res0_valid;
  assign elig1  = req1_valid & ~res1_valid;
  // rr=1 favours requester 1; a lone eligible requester always wins.
  assign grant1 = elig1 & (~elig0 | rr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr         <= 1'b0;
      owner      <= 1'b0;
      timer      <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      res0_valid <= 1'b0;
      res1_valid <= 1'b0;
      res0_y     <= '0;
      res1_y     <= '0;
      mul_start  <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      busy       <= 1'b0;
      err_to     <= 1'b0;
      err_id     <= 1'b0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      err_to     <= 1'b0;
      if (res0_ack) res0_valid <= 1'b0;
      if (res1_ack) res1_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (mul_aval && (elig0 || elig1)) begin
            owner <= grant1;
            rr    <= ~grant1;
            timer <= '0;
            busy  <= 1'b1;
            state <= ISSUE;
            if (grant1) begin
              req1_ready <= 1'b1;
              mul_a      <= req1_a;
              mul_b      <= req1_b;
            end else begin
              req0_ready <= 1'b1;
              mul_a      <= req0_a;
              mul_b      <= req0_b;
            end
          end
        end

        // First ISSUE cycle only raises start, so start trails ready by one cycle.
        ISSUE: begin
          if (!mul_start) begin
            mul_start <= 1'b1;
          end else if (mul_done) begin
            if (owner) begin
              res1_y     <= mul_y;
              res1_valid <= 1'b1;
            end else begin
              res0_y     <= mul_y;
              res0_valid <= 1'b1;
            end
            mul_start <= 1'b0;
            state     <= RELEASE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            err_to    <= 1'b1;
            err_id    <= owner;
            mul_start <= 1'b0;
            state     <= RELEASE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        RELEASE: begin
          if (!mul_done && mul_aval) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural multiplier (done 10 cycles
// after start) and a scoreboard of expected products in grant order.
module tb_mul_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        res0_valid, res1_valid, res0_ack, res1_ack;
  logic [15:0] res0_y, res1_y;
  logic        mul_start, mul_done, mul_aval;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_y;
  logic        busy, err_to, err_id;
  logic        no_done;
  int          m_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        id;
    logic [15:0] y;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mul_share_arbiter #(.N(8), .M(8), .TIMEOUT(64), .TW(7)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res0_valid(res0_valid), .res0_y(res0_y), .res0_ack(res0_ack),
    .res1_valid(res1_valid), .res1_y(res1_y), .res1_ack(res1_ack),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
    .mul_done(mul_done), .mul_aval(mul_aval),
    .busy(busy), .err_to(err_to), .err_id(err_id)
  );

  // Behavioural multiplier: done rises 10 cycles after start, held until start drops.
  assign mul_aval = ~mul_done;
  always @(posedge clk) begin
    if (rst || !mul_start) begin
      m_cnt    <= 0;
      mul_done <= 1'b0;
    end else if (!mul_done && !no_done) begin
      if (m_cnt == 9) begin
        mul_done <= 1'b1;
        mul_y    <= 16'($signed(mul_a) * $signed(mul_b));
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb_;
    sa  = {{8{a[7]}}, a};
    sb_ = {{8{b[7]}}, b};
    return 16'(sa * sb_);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output int who);
    who = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (req0_ready) begin who = 0; break; end
      if (req1_ready) begin who = 1; break; end
    end
  endtask

  task automatic wait_res(input string tag, input int k, output int lat);
    logic found;
    exp_t e;
    found = 1'b0;
    lat   = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      lat++;
      if ((k == 0 && res0_valid) || (k == 1 && res1_valid)) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_res_seen"}, 64'(found), 64'd1);
    if (found) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        chk({tag, "_res_id"}, 64'(k), 64'(e.id));
        chk({tag, "_res_y"}, 64'((k == 0) ? res0_y : res1_y), 64'(e.y));
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      tick();
    end
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  function automatic logic [63:0] outs();
    return 64'({req0_ready, req1_ready, res0_valid, res1_valid, mul_start, busy,
                err_to, err_id, mul_a, mul_b, res0_y, res1_y});
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int who, lat, cnt;
    logic seen;
    logic [15:0] y0_hold;
    int order[$];

    rst = 1'b1; no_done = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    res0_ack = 0; res1_ack = 0;
    repeat (3) tick();
    chk("reset_outs", outs(), 64'd0);
    rst = 1'b0;

    // 1: req0 89*10
    req0_a = 8'd89; req0_b = 8'd10; req0_valid = 1'b1;
    sb.push_back('{1'b0, 16'h037A});
    wait_grant(who);
    chk("t1_grant", 64'(who), 64'd0);
    chk("t1_start_low_at_ready", 64'(mul_start), 64'd0);
    req0_valid = 1'b0;
    tick();
    chk("t1_start", 64'(mul_start), 64'd1);
    chk("t1_mul_ab", 64'({mul_a, mul_b}), 64'({8'd89, 8'd10}));
    wait_res("t1", 0, lat);
    chk("t1_latency", 64'(lat), 64'd11);
    tick(); tick();
    chk("t1_hold_valid", 64'(res0_valid), 64'd1);
    chk("t1_start_dropped", 64'(mul_start), 64'd0);
    res0_ack = 1'b1; tick(); res0_ack = 1'b0;
    chk("t1_ack_clears", 64'(res0_valid), 64'd0);
    wait_idle("t1");

    // 2: req1 -89*10
    req1_a = 8'hA7; req1_b = 8'd10; req1_valid = 1'b1;
    sb.push_back('{1'b1, 16'hFC86});
    wait_grant(who);
    chk("t2_grant", 64'(who), 64'd1);
    req1_valid = 1'b0;
    wait_res("t2", 1, lat);
    chk("t2_res0_untouched", 64'({res0_valid, res0_y}), 64'({1'b0, 16'h037A}));
    res1_ack = 1'b1; tick(); res1_ack = 1'b0;
    wait_idle("t2");

    // 3: both valid after reset, immediate acks -> 0,1,0,1
    rst = 1'b1; tick(); rst = 1'b0;
    order = '{0, 1, 0, 1};
    req0_a = 8'd3;  req0_b = 8'hF9;
    req1_a = 8'h80; req1_b = 8'h7F;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_grant(who);
      chk("t3_grant_order", 64'(who), 64'(order.pop_front()));
      if (who == 1) begin
        sb.push_back('{1'b1, prod(req1_a, req1_b)});
        wait_res("t3", 1, lat);
        res1_ack = 1'b1; tick(); res1_ack = 1'b0;
        req1_a = req1_a + 8'd37;
      end else begin
        sb.push_back('{1'b0, prod(req0_a, req0_b)});
        wait_res("t3", 0, lat);
        res0_ack = 1'b1; tick(); res0_ack = 1'b0;
        req0_a = req0_a + 8'd41;
      end
    end

    // 4: res0 left pending blocks req0 until acked
    wait_grant(who);
    chk("t4_first", 64'(who), 64'd0);
    sb.push_back('{1'b0, prod(req0_a, req0_b)});
    wait_res("t4a", 0, lat);
    y0_hold = res0_y;
    for (int g = 0; g < 2; g++) begin
      wait_grant(who);
      chk("t4_only_req1", 64'(who), 64'd1);
      sb.push_back('{1'b1, prod(req1_a, req1_b)});
      wait_res("t4b", 1, lat);
      chk("t4_res0_held", 64'({res0_valid, res0_y}), 64'({1'b1, y0_hold}));
      if (g == 0) begin
        res1_ack = 1'b1; tick(); res1_ack = 1'b0;
      end
      req1_a = req1_a + 8'd11;
    end
    res0_ack = 1'b1; res1_ack = 1'b1; tick(); res0_ack = 1'b0; res1_ack = 1'b0;
    req0_a = 8'hFF; req0_b = 8'hFF;
    wait_grant(who);
    chk("t4_req0_after_ack", 64'(who), 64'd0);
    sb.push_back('{1'b0, 16'h0001});
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_res("t4c", 0, lat);
    res0_ack = 1'b1; tick(); res0_ack = 1'b0;
    wait_idle("t4");

    // 5: multiplier never finishes -> timeout abort
    no_done = 1'b1;
    req1_a = 8'd5; req1_b = 8'd6; req1_valid = 1'b1;
    wait_grant(who);
    chk("t5_grant", 64'(who), 64'd1);
    req1_valid = 1'b0;
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (err_to) begin seen = 1'b1; break; end
      if (mul_start) cnt++;
    end
    chk("t5_err_to_seen", 64'(seen), 64'd1);
    chk("t5_start_cycles", 64'(cnt), 64'd64);
    chk("t5_err_state", 64'({err_id, mul_start, res0_valid, res1_valid}), 64'({1'b1, 3'b000}));
    tick();
    chk("t5_err_pulse", 64'({err_to, err_id}), 64'({1'b0, 1'b1}));
    wait_idle("t5");
    chk("t5_no_result", 64'({res0_valid, res1_valid}), 64'd0);
    no_done = 1'b0;

    // 6: reset during ISSUE, then a fresh request
    req0_a = 8'd12; req0_b = 8'd12; req0_valid = 1'b1;
    wait_grant(who);
    chk("t6_grant", 64'(who), 64'd0);
    req0_valid = 1'b0;
    repeat (3) tick();
    chk("t6_in_issue", 64'(mul_start), 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_reset_outs", outs(), 64'd0);
    req0_a = 8'hF6; req0_b = 8'd13; req1_a = 8'd7; req1_b = 8'd7;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_grant(who);
    chk("t6_req0_favoured", 64'(who), 64'd0);
    sb.push_back('{1'b0, 16'hFF7E});
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_res("t6", 0, lat);
    res0_ack = 1'b1; tick(); res0_ack = 1'b0;
    wait_idle("t6");
    chk("t6_sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
